fp_addsub: RTL
==============

Name: fp_addsub

Overview:
Parametrised IEEE-754 floating-point adder/subtractor, the successor to the single-precision adder in the FPU. Exponent and mantissa widths are generic, so one block covers half, single and double precision. Adds an add/subtract mode, fixed latency, single-cycle barrel alignment and normalisation, and optional IEEE exception flags. It sits beside the other FPU arithmetic units behind the same start/done handshake.

Parameters:
EXP_W, 8, exponent field width (>=4); BIAS = 2^(EXP_W-1)-1
MAN_W, 23, stored fraction width (>=4); DATA_W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  operation request, sampled only while idle
op  in  1  0 = a+b, 1 = a-b (sampled with start)
op_a  in  DATA_W  operand a (sampled with start)
op_b  in  DATA_W  operand b (sampled with start)
done  out  1  high when idle; result on res valid
res  out  DATA_W  result, held until the next completion
flags  out  4  {invalid, overflow, underflow, inexact}; present only with FP_ADDSUB_FLAGS_EN

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, res=0, done=1, flags=0. Reset during an operation aborts it; nothing is written to res.
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> PACK -> IDLE. One cycle per state. No data-dependent looping.
- Latency: start high in IDLE at edge T registers op_a, op_b and op. done is low for exactly 6 cycles. res (and flags) update at the edge where done returns high.
- start while busy is ignored. start in the first IDLE cycle after PACK is accepted, giving back-to-back throughput of one result per 7 cycles.
- UNPACK:
  - op=1 inverts b's sign.
  - Exponent field 0 marks a denormal: effective exponent 1-BIAS, hidden bit 0. Otherwise the hidden bit is 1.
  - Special cases are detected here. Their result is carried through the pipeline unchanged, so latency stays 6.
- Special-case priority:
  1. Any NaN, or inf + inf with opposite effective signs -> canonical qNaN {1, all-ones, 1, zeros}; invalid set.
  2. Any inf -> that inf.
  3. Both zero -> zero with sign a_s AND b_s(eff).
  4. One zero -> the other operand, bit-exact.
- ALIGN: swap so |a|>=|b|. Right-shift the smaller mantissa by the exponent difference in one cycle. The datapath is MAN_W+4 bits (hidden + fraction + guard + round + sticky). Every bit shifted out ORs into sticky. A difference >= MAN_W+3 collapses the mantissa to sticky only.
- ADD: magnitude add or subtract (MAN_W+5 bits including carry). Result sign is the sign of the larger magnitude. An exact zero result is +0.
- NORM:
  - Carry out: shift right 1, exponent +1, sticky accumulates.
  - Otherwise: leading-zero count, then left shift clamped so the exponent does not go below 1-BIAS. A clamped result is a denormal.
- ROUND: round-to-nearest-even on guard/round/sticky. A mantissa carry-out increments the exponent; a denormal rounding up to min-normal becomes normal.
- PACK:
  - Exponent > BIAS -> signed inf; overflow and inexact set.
  - Denormal or zero -> exponent field 0.
  - inexact = any of guard/round/sticky nonzero before rounding.
  - underflow = tiny result AND inexact.

Optional Feature:
FP_ADDSUB_FLAGS_EN:
- Defined: the flags port exists. It is registered with res at PACK, reset to 0, and reflects only the most recent operation (not sticky across operations).
- Undefined: the flags port and all flag logic are absent. res behaviour is identical.

Test Plan:
- Default params: op_a=0x3F800000, op_b=0x40000000, op=0 -> res=0x40400000; done low exactly 6 cycles; start pulsed while busy is ignored.
- op=1, op_a=op_b=0x3F800000 -> res=0x00000000 (+0). Same with 0xBF800000 for both -> 0x00000000.
- Specials: 0x7F800000 + 0xFF800000 -> 0xFFC00000 with invalid. 0x7FC00001 + 0x3F800000 -> 0xFFC00000. 0x80000000 + 0x80000000 -> 0x80000000.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with overflow and inexact.
- Denormals and ties:
  - 0x00000001 + 0x00000001 -> 0x00000002.
  - op=1, 0x00800000 - 0x00000001 -> 0x007FFFFF.
  - 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even, inexact).
  - 0x3F800000 + 0x33C00000 -> 0x3F800001.
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000. Assert rst_n low mid-operation -> done=1 and res=0 immediately; the next operation completes normally.

Source files
------------

// File: rtl/fp_addsub_if.sv
// Request/result bundle for fp_addsub: start/op/operands in, done/res (and flags
// when FP_ADDSUB_FLAGS_EN is defined) out.
interface fp_addsub_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int DATA_W = 1 + EXP_W + MAN_W;

  // Handshake: start is sampled together with op/op_a/op_b only while done is
  // high; done stays low while the operation is in flight and returns high on
  // the same edge that loads res, which then holds until the next completion.
  logic              start;
  logic              op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              done;
  logic [DATA_W-1:0] res;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0]        flags;

  modport master (output start, op, op_a, op_b, input done, res, flags);
  modport slave  (input start, op, op_a, op_b, output done, res, flags);
`else
  modport master (output start, op, op_a, op_b, input done, res);
  modport slave  (input start, op, op_a, op_b, output done, res);
`endif
endinterface

// File: rtl/fp_addsub.sv
// Parametrised IEEE-754 add/subtract, fixed 6-cycle busy time, round-to-nearest-even.
// Define FP_ADDSUB_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags.
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_addsub_if.slave   bus,
  output logic [2:0]   o_dbg_state
);
  localparam int DATA_W = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int SW     = MAN_W + 5;  // plus carry
  localparam int LZW    = $clog2(MAN_W + 5);
  localparam int XW     = ((EXP_W + 2) > (LZW + 1)) ? (EXP_W + 2) : (LZW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_a, r_b, r_spec_res, r_res;
  logic              r_op, r_spec;
  logic              r_sa, r_sb, r_sub, r_sign;
  logic [XW-1:0]     r_ea, r_eb, r_exp;
  logic [MAN_W:0]    r_ma, r_mb, r_man;
  logic [MW-1:0]     r_mx, r_my, r_nm;
  logic [SW-1:0]     r_sum;
`ifdef FP_ADDSUB_FLAGS_EN
  logic              r_spec_inv, r_inx;
  logic [3:0]        r_flags;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_UNPACK;
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ADD;
      S_ADD:    w_next = S_NORM;
      S_NORM:   w_next = S_ROUND;
      S_ROUND:  w_next = S_PACK;
      S_PACK:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign bus.done    = (r_state == S_IDLE);
  assign bus.res     = r_res;
  assign o_dbg_state = r_state;
`ifdef FP_ADDSUB_FLAGS_EN
  assign bus.flags   = r_flags;
`endif

  // ---- UNPACK: field split and special-case resolution
  logic               w_a_s, w_b_s;
  logic [EXP_W-1:0]   w_a_e, w_b_e;
  logic [MAN_W-1:0]   w_a_f, w_b_f;
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic               w_spec, w_spec_inv;
  logic [DATA_W-1:0]  w_spec_res;

  assign w_a_s    = r_a[DATA_W-1];
  assign w_b_s    = r_b[DATA_W-1] ^ r_op;
  assign w_a_e    = r_a[DATA_W-2:MAN_W];
  assign w_b_e    = r_b[DATA_W-2:MAN_W];
  assign w_a_f    = r_a[MAN_W-1:0];
  assign w_b_f    = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_a_e) & (|w_a_f);
  assign w_b_nan  = (&w_b_e) & (|w_b_f);
  assign w_a_inf  = (&w_a_e) & ~(|w_a_f);
  assign w_b_inf  = (&w_b_e) & ~(|w_b_f);
  assign w_a_zero = ~(|w_a_e) & ~(|w_a_f);
  assign w_b_zero = ~(|w_b_e) & ~(|w_b_f);

  always_comb begin
    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_s != w_b_s))) begin
      w_spec_res = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = r_a;
    end else if (w_b_inf) begin
      w_spec_res = {w_b_s, r_b[DATA_W-2:0]};
    end else if (w_a_zero && w_b_zero) begin
      w_spec_res = {w_a_s & w_b_s, {(DATA_W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_spec_res = {w_b_s, r_b[DATA_W-2:0]};
    end else if (w_b_zero) begin
      w_spec_res = r_a;
    end else begin
      w_spec = 1'b0;
    end
  end

  // ---- ALIGN: order by magnitude, shift the smaller one with sticky collection
  logic             w_a_big;
  logic [XW-1:0]    w_e_big, w_e_small, w_diff;
  logic [MAN_W:0]   w_m_big, w_m_small;
  logic [MW-1:0]    w_sext, w_shifted;
  logic             w_lost;

  assign w_a_big   = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_e_big   = w_a_big ? r_ea : r_eb;
  assign w_e_small = w_a_big ? r_eb : r_ea;
  assign w_m_big   = w_a_big ? r_ma : r_mb;
  assign w_m_small = w_a_big ? r_mb : r_ma;
  assign w_diff    = w_e_big - w_e_small;
  assign w_sext    = {w_m_small, 3'b000};
  assign w_lost    = |(w_sext & ~({MW{1'b1}} << w_diff));

  always_comb begin
    if (w_diff >= XW'(MAN_W + 3))
      w_shifted = {{(MW-1){1'b0}}, |w_m_small};
    else
      w_shifted = (w_sext >> w_diff) | {{(MW-1){1'b0}}, w_lost};
  end

  // ---- ADD
  logic [SW-1:0] w_sum;
  assign w_sum = r_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});

  // ---- NORM: right by one on carry, else left by leading zeros clamped at min exponent
  logic [XW-1:0] w_lz, w_lim, w_sh, w_ne;
  logic [MW-1:0] w_nm;

  always_comb begin
    w_lz = XW'(MW);
    for (int i = 0; i < MW; i++)
      if (r_sum[i]) w_lz = XW'(MW - 1 - i);
    w_lim = r_exp - XW'(1);
    w_sh  = (w_lz < w_lim) ? w_lz : w_lim;
    if (r_sum[MW]) begin
      w_nm = {r_sum[MW:2], r_sum[1] | r_sum[0]};
      w_ne = r_exp + XW'(1);
    end else begin
      w_nm = r_sum[MW-1:0] << w_sh;
      w_ne = r_exp - w_sh;
    end
  end

  // ---- ROUND: nearest-even on guard/round/sticky
  logic           w_rup;
  logic [MAN_W+1:0] w_rm;
  assign w_rup = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
  assign w_rm  = {1'b0, r_nm[MW-1:3]} + (MAN_W+2)'(w_rup);

  // ---- PACK
  logic              w_ovf, w_tiny;
  logic [DATA_W-1:0] w_res;
  assign w_ovf  = (r_exp >= XW'((1 << EXP_W) - 1));
  assign w_tiny = ~r_man[MAN_W];

  always_comb begin
    if (r_spec)     w_res = r_spec_res;
    else if (w_ovf) w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_tiny) w_res = {r_sign, {EXP_W{1'b0}}, r_man[MAN_W-1:0]};
    else            w_res = {r_sign, r_exp[EXP_W-1:0], r_man[MAN_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_b <= '0; r_op <= 1'b0;
      r_spec <= 1'b0; r_spec_res <= '0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_ea <= '0; r_eb <= '0; r_ma <= '0; r_mb <= '0;
      r_mx <= '0; r_my <= '0; r_sub <= 1'b0; r_sign <= 1'b0; r_exp <= '0;
      r_sum <= '0; r_nm <= '0; r_man <= '0; r_res <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
      r_spec_inv <= 1'b0; r_inx <= 1'b0; r_flags <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a  <= bus.op_a;
          r_b  <= bus.op_b;
          r_op <= bus.op;
        end
        S_UNPACK: begin
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_sa       <= w_a_s;
          r_sb       <= w_b_s;
          // Denormals use exponent 1 with hidden bit 0, so {exp, mantissa} orders magnitude.
          r_ea       <= (w_a_e == '0) ? XW'(1) : XW'(w_a_e);
          r_eb       <= (w_b_e == '0) ? XW'(1) : XW'(w_b_e);
          r_ma       <= {|w_a_e, w_a_f};
          r_mb       <= {|w_b_e, w_b_f};
`ifdef FP_ADDSUB_FLAGS_EN
          r_spec_inv <= w_spec_inv;
`endif
        end
        S_ALIGN: begin
          r_mx   <= {w_m_big, 3'b000};
          r_my   <= w_shifted;
          r_exp  <= w_e_big;
          r_sign <= w_a_big ? r_sa : r_sb;
          r_sub  <= r_sa ^ r_sb;
        end
        S_ADD: begin
          r_sum <= w_sum;
          if (w_sum == '0) r_sign <= 1'b0;
        end
        S_NORM: begin
          r_nm  <= w_nm;
          r_exp <= w_ne;
        end
        S_ROUND: begin
          if (w_rm[MAN_W+1]) begin
            r_man <= w_rm[MAN_W+1:1];
            r_exp <= r_exp + XW'(1);
          end else begin
            r_man <= w_rm[MAN_W:0];
          end
`ifdef FP_ADDSUB_FLAGS_EN
          r_inx <= |r_nm[2:0];
`endif
        end
        S_PACK: begin
          r_res <= w_res;
`ifdef FP_ADDSUB_FLAGS_EN
          if (r_spec) r_flags <= {r_spec_inv, 3'b000};
          else        r_flags <= {1'b0, w_ovf, w_tiny & r_inx, r_inx | w_ovf};
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
